// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive blocks.
//   tx_state_t : transmitter FSM states
//   LINE_IDLE  : level of an idle UART line (mark)
//   baud_div() : clock cycles per bit, integer-truncated CLK_FREQ / BAUD
//   cnt_width(): width of a counter that spans 0..div-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;

   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // A divide-by-one counter still needs a 1-bit register to be declarable.
   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO built on a circular buffer.
// Pointers carry one extra wrap bit so full and empty are told apart by the
// pointer MSB compare. Writes while full and reads while empty are ignored.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (pointers only)
//   wr    : write strobe, wdata is stored when wr=1 and full=0
//   wdata : write data, WIDTH bits
//   rd    : read strobe, advances the head when rd=1 and empty=0
//   rdata : current head entry (valid while empty=0)
//   full  : DEPTH entries held
//   empty : no entries held
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_wr;
   logic             do_rd;

   // The full check uses the value before this edge, so a write on the cycle
   // full is high is dropped even if a pop frees a slot in the same cycle.
   assign do_wr = wr && !full;
   assign do_rd = rd && !empty;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered UART transmitter. Bytes strobed in with valid are queued in a
// sync_fifo and sent LSB first as back-to-back 8N1 frames (8E1 when the
// UART_TX_PARITY_EN macro is defined, which inserts an even-parity bit).
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset; aborts any frame, empties FIFO
//   valid : write strobe, data captured when valid=1 and full=0
//   data  : byte to transmit
//   dout  : serial TX line, idle high, driven straight from a flop
//   full  : FIFO holds DEPTH bytes
//   busy  : a frame is on the line or the FIFO is non-empty
// Parameters: CLK_FREQ (Hz), BAUD (bit/s), DEPTH (bytes, power of two >= 2).
// ---------------------------------------------------------------------------
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 9600,
   parameter int DEPTH    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       dout,
   output logic       full,
   output logic       busy
);

   localparam int                BAUD_DIV = baud_div(CLK_FREQ, BAUD);
   localparam int                CNT_W    = cnt_width(BAUD_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_DIV - 1);

   tx_state_t        state;
   tx_state_t        state_next;
   logic [CNT_W-1:0] baud_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [7:0]       shift;
   logic [7:0]       shift_next;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_next;
   logic             dout_q;
   logic             dout_next;
   logic             pop;
   logic             bit_end;
   logic             empty;
   logic [7:0]       head;
`ifdef UART_TX_PARITY_EN
   logic             parity_q;
   logic             parity_next;
`endif

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (valid),
      .wdata (data),
      .rd    (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign bit_end = (baud_cnt == CNT_LAST);

   // State register, with the datapath registers that move alongside it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         shift    <= '0;
         bit_idx  <= '0;
         dout_q   <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         baud_cnt <= cnt_next;
         shift    <= shift_next;
         bit_idx  <= bit_idx_next;
         dout_q   <= dout_next;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_next;
`endif
      end
   end

   // Next-state logic. The FIFO head is popped on leaving IDLE and again at
   // the end of a stop bit, so queued bytes follow with no idle gap.
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (bit_end) state_next = DATA;
         end
         DATA: begin
            if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_next = STOP;
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (!empty) begin
                  pop        = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output and datapath logic. The line level is computed for the state
   // being entered and registered, so dout changes on the same edge as the
   // state and has no combinational path from the inputs.
   always_comb begin
      cnt_next     = (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      shift_next   = shift;
      bit_idx_next = bit_idx;
`ifdef UART_TX_PARITY_EN
      parity_next  = parity_q;
`endif
      if (pop) begin
         shift_next   = head;
         bit_idx_next = 3'd0;
`ifdef UART_TX_PARITY_EN
         parity_next  = ^head;
`endif
      end else if (state == DATA && bit_end) begin
         shift_next   = {1'b0, shift[7:1]};
         bit_idx_next = bit_idx + 3'd1;
      end

      case (state_next)
         START:   dout_next = 1'b0;
         DATA:    dout_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  dout_next = parity_next;
`endif
         default: dout_next = LINE_IDLE;
      endcase
   end

   assign dout = dout_q;
   assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo at CLK_FREQ=16, BAUD=1 (16 cycles per
// bit) and DEPTH=4. A table of bytes with hand-written frame bit patterns is
// sent one frame at a time; hand-written sequences cover bursts, overflow,
// a write coinciding with a pop while full, and reset mid-frame.
// Define UART_TX_PARITY_EN to exercise the 8E1 build.
// Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

   localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   typedef struct {
      logic [7:0]  data;
      logic [10:0] bits;   // bit 0 = start, then d0..d7, (parity), stop
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data = 8'h00;
   logic       dout;
   logic       full;
   logic       busy;

   int checks = 0;
   int errors = 0;

   vec_t vecs[5];

   uart_tx_fifo #(
      .CLK_FREQ (16),
      .BAUD     (1),
      .DEPTH    (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .valid (valid),
      .data  (data),
      .dout  (dout),
      .full  (full),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      valid = 1'b1;
      data  = b;
      tick(1);
      valid = 1'b0;
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b0, 1'b1, b, 1'b0};
`endif
   endfunction

   // Entered "offset" cycles into the start bit. Checks every bit on its
   // first and last cycle; returns on the first cycle after the stop bit.
   task automatic check_frame(input logic [10:0] bits, input int offset,
                              input string tag);
      for (int k = 0; k < NB; k++) begin
         check($sformatf("%s_bit%0d_first", tag, k), dout, bits[k]);
         tick(DIV - 1 - ((k == 0) ? offset : 0));
         check($sformatf("%s_bit%0d_last", tag, k), dout, bits[k]);
         if (k == NB - 1) check($sformatf("%s_busy_stop", tag), busy, 1'b1);
         tick(1);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_idle_dout"}, dout, 1'b1);
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_idle_full"}, full, 1'b0);
   endtask

   logic any_low;

   initial begin
`ifdef UART_TX_PARITY_EN
      vecs[0] = '{8'h07, 11'b1_1_0000_0111_0};
      vecs[1] = '{8'h03, 11'b1_0_0000_0011_0};
      vecs[2] = '{8'h55, 11'b1_0_0101_0101_0};
      vecs[3] = '{8'hFF, 11'b1_0_1111_1111_0};
      vecs[4] = '{8'h01, 11'b1_1_0000_0001_0};
`else
      vecs[0] = '{8'h55, 11'b0_1_0101_0101_0};
      vecs[1] = '{8'hA3, 11'b0_1_1010_0011_0};
      vecs[2] = '{8'h0F, 11'b0_1_0000_1111_0};
      vecs[3] = '{8'hFF, 11'b0_1_1111_1111_0};
      vecs[4] = '{8'h00, 11'b0_1_0000_0000_0};
`endif

      // Reset state
      tick(3);
      check("rst_dout", dout, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick(2);
      check_idle("post_rst");

      // Single frames from the table: write at E0, start bit from E1.
      for (int v = 0; v < 5; v++) begin
         write_byte(vecs[v].data);
         check($sformatf("vec%0d_busy_after_write", v), busy, 1'b1);
         tick(1);
         check_frame(vecs[v].bits, 0, $sformatf("vec%0d", v));
         check_idle($sformatf("vec%0d", v));
         tick(3);
      end

      // Burst: three frames back-to-back with no idle gap.
      write_byte(8'hA3);
      write_byte(8'h0F);
      write_byte(8'hFF);
      check_frame(frame_bits(8'hA3), 1, "burst0");
      check_frame(frame_bits(8'h0F), 0, "burst1");
      check_frame(frame_bits(8'hFF), 0, "burst2");
      check_idle("burst");
      tick(3);

      // Overflow: 0x01 popped at E1, 0x02..0x05 fill the FIFO, 0x06 dropped.
      for (int i = 1; i <= 6; i++) begin
         write_byte(8'(i));
         check($sformatf("ovf_full_after_w%0d", i), full, (i >= 5));
      end
      check_frame(frame_bits(8'h01), 4, "ovf1");
      for (int i = 2; i <= 5; i++)
         check_frame(frame_bits(8'(i)), 0, $sformatf("ovf%0d", i));
      check_idle("ovf");
      tick(3);

      // Write coinciding with the pop at a stop-bit end while full.
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      write_byte(8'h44);
      write_byte(8'h55);
      check("simul_full_filled", full, 1'b1);
      tick(DIV * NB - 4);
      check("simul_full_before_pop", full, 1'b1);
      write_byte(8'h99);
      check("simul_full_after_pop", full, 1'b0);
      write_byte(8'h66);
      check("simul_full_refilled", full, 1'b1);
      check_frame(frame_bits(8'h22), 1, "simul22");
      check_frame(frame_bits(8'h33), 0, "simul33");
      check_frame(frame_bits(8'h44), 0, "simul44");
      check_frame(frame_bits(8'h55), 0, "simul55");
      check_frame(frame_bits(8'h66), 0, "simul66");
      check_idle("simul");
      tick(3);

      // Reset during data bit 3 of 0xC6 with two bytes queued.
      write_byte(8'hC6);
      write_byte(8'h01);
      write_byte(8'h02);
      tick(67);
      check("rstmid_bit3", dout, 1'b0);
      check("rstmid_busy_before", busy, 1'b1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rstmid_dout", dout, 1'b1);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_full", full, 1'b0);
      any_low = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (dout !== 1'b1 || busy !== 1'b0) any_low = 1'b1;
         tick(1);
      end
      check("rstmid_quiet", any_low, 1'b0);
      write_byte(8'h3C);
      tick(1);
      check_frame(frame_bits(8'h3C), 0, "rstmid_recover");
      check_idle("rstmid_recover");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
